apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB3 requester. Converts single-beat commands from a local valid/ready command port into APB SETUP/ACCESS transfers.
- Returns one response per command: read data plus error and timeout flags.
- Drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA side of our APB slave memory block and any other APB3 completer.
- Sits between the bus-bridge/CPU-side logic and the APB peripheral segment.

Parameters:
- ADDR_W, 32, width of cmd_addr/PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 = timeout disabled

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset: PRESETn asynchronous, active-low; clock PCLK. On reset all outputs go to 0, state to IDLE, timeout counter to 0.
- All APB outputs and rsp_* are registered.
- cmd_ready = (state == IDLE), decoded from the state register only.
- FSM IDLE -> SETUP:
  - Taken on cmd_valid & cmd_ready.
  - cmd_write, cmd_addr and cmd_wdata are captured into PWRITE, PADDR and PWDATA.
  - PSEL=1, PENABLE=0 in SETUP.
- FSM SETUP -> ACCESS: unconditional. PENABLE=1, PSEL=1.
- FSM ACCESS:
  - PREADY=1: transfer completes and state goes to IDLE.
    - Next cycle: PSEL=0, PENABLE=0, rsp_valid=1.
    - rsp_err = PSLVERR.
    - rsp_rdata = PRDATA for reads, 0 for writes.
    - rsp_timeout = 0.
  - PREADY=0: stay in ACCESS and increment the wait counter.
  - Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT (TIMEOUT consecutive PREADY=0 ACCESS cycles), abort and go to IDLE.
    - Next cycle: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. Between transfers they hold their last values.
- PREADY, PRDATA and PSLVERR are ignored outside ACCESS. PSLVERR is only sampled in the PREADY=1 ACCESS cycle.
- Minimum latency: command accept edge to rsp_valid high is 3 cycles (SETUP, ACCESS, response). Each wait state adds 1 cycle.
- Back-to-back commands:
  - The response cycle is IDLE, so cmd_ready=1 in the same cycle rsp_valid=1.
  - A new command can be accepted there, giving 1 IDLE cycle between transfers (PSEL low for one cycle).
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously), no response is issued for the in-flight command, and the FSM restarts in IDLE.
- TIMEOUT=0: the master waits indefinitely on PREADY=0.

Test Plan:
- Zero-wait write: cmd addr=0x10, wdata=0xDEADBEEF, PREADY=1 in ACCESS -> PSEL high 2 cycles, PENABLE high 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read, 2 wait states: addr=0x20, PREADY low 2 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR stable for 4 cycles, rsp_rdata=0x12345678 at cycle 5 after accept.
- Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0. PSLVERR=1 during SETUP alone has no effect.
- Timeout (TIMEOUT=16): PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 next cycle. Next command proceeds normally.
- Back-to-back: cmd_valid held high for 3 writes -> exactly 3 rsp_valid pulses, one IDLE cycle between transfers, no PENABLE without a prior SETUP cycle.
- Reset in ACCESS: assert PRESETn=0 while PREADY=0 -> PSEL/PENABLE=0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_if.sv
// APB3 bus bundle between a requester and a completer.
// The master modport drives select/enable/address/direction/write data;
// the slave modport drives read data, ready and error back.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: turns single-beat local commands into SETUP/ACCESS
// transfers and returns one response (read data, error, timeout) per command.
//
// Handshake: a command transfers on a rising PCLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while the FSM is IDLE.
// The response side has no backpressure: rsp_valid pulses for one cycle and
// rsp_rdata/rsp_err/rsp_timeout hold until the next response.
module apb_master #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_master_if.master      apb,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // The counter only has to reach TIMEOUT-1: the abort fires on the
    // TIMEOUT-th not-ready ACCESS cycle itself.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic               accept;
    logic               done;
    logic               abort;
    logic               timeout_hit;

    assign cmd_ready = (state == IDLE);
    assign state_dbg = state;

    // TIMEOUT == 0 never matches, so the master waits forever on PREADY=0.
    assign timeout_hit = (TIMEOUT != 0) && (32'(wait_cnt) == TIMEOUT - 1);

    // State register; reset forces IDLE immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus the single-cycle events that load the outputs.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Consecutive not-ready ACCESS cycles; zero everywhere outside ACCESS,
    // so every transfer starts counting from zero.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!apb.PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Registered APB outputs: PSEL/PENABLE follow the next state so they are
    // aligned with the state register; address/direction/data load only on
    // accept and therefore hold between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
        end else begin
            apb.PSEL    <= (state_n != IDLE);
            apb.PENABLE <= (state_n == ACCESS);
            if (accept) begin
                apb.PWRITE <= cmd_write;
                apb.PADDR  <= cmd_addr;
                apb.PWDATA <= cmd_wdata;
            end
        end
    end

    // Registered response: one pulse per completed or aborted transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= done | abort;
            if (done) begin
                rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                rsp_err     <= apb.PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: reset, zero-wait write, waited read,
// slave error, timeout, back-to-back commands and reset during ACCESS.
module tb_apb_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [1:0]        state_dbg;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int vectors     = 0;
    int miscompares = 0;
    int rsp_cnt     = 0;
    int proto_viol  = 0;
    int base_cnt;
    logic prev_setup = 1'b0;
    logic prev_en    = 1'b0;

    // Bus monitor: counts response pulses and flags a PENABLE rise that was
    // not preceded by a SETUP cycle.
    always @(negedge PCLK) begin
        if (rsp_valid) rsp_cnt++;
        if (apb.PENABLE && !prev_en && !prev_setup) proto_viol++;
        prev_setup = apb.PSEL && !apb.PENABLE;
        prev_en    = apb.PENABLE;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // Present a command at the current negedge; it is accepted on the next posedge.
    task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        PRESETn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        apb.PRDATA  = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_psel",    64'(apb.PSEL), 64'd0);
        chk("rst_penable", 64'(apb.PENABLE), 64'd0);
        chk("rst_rsp",     64'(rsp_valid), 64'd0);
        chk("rst_paddr",   64'(apb.PADDR), 64'd0);
        PRESETn = 1'b1;
        step();
        chk("rst_ready",   64'(cmd_ready), 64'd1);
        chk("rst_state",   64'(state_dbg), 64'd0);

        // ---- zero-wait write ----
        apb.PREADY = 1'b1;
        drive_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        step();                                  // SETUP
        cmd_valid = 1'b0;
        chk("w0_setup_psel", 64'(apb.PSEL), 64'd1);
        chk("w0_setup_pen",  64'(apb.PENABLE), 64'd0);
        chk("w0_paddr",      64'(apb.PADDR), 64'h10);
        chk("w0_pwdata",     64'(apb.PWDATA), 64'hDEADBEEF);
        chk("w0_pwrite",     64'(apb.PWRITE), 64'd1);
        chk("w0_ready_busy", 64'(cmd_ready), 64'd0);
        step();                                  // ACCESS
        chk("w0_acc_pen",    64'(apb.PENABLE), 64'd1);
        chk("w0_acc_state",  64'(state_dbg), 64'd2);
        step();                                  // response
        chk("w0_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("w0_rsp_err",    64'(rsp_err), 64'd0);
        chk("w0_rsp_rdata",  64'(rsp_rdata), 64'd0);
        chk("w0_psel_low",   64'(apb.PSEL), 64'd0);
        chk("w0_ready_rsp",  64'(cmd_ready), 64'd1);
        step();
        chk("w0_rsp_pulse",  64'(rsp_valid), 64'd0);
        chk("w0_paddr_hold", 64'(apb.PADDR), 64'h10);

        // ---- read with two wait states ----
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'hBADBAD00;
        drive_cmd(1'b0, 32'h20, 32'h0);
        step();                                  // SETUP
        cmd_valid = 1'b0;
        chk("r2_paddr_s",    64'(apb.PADDR), 64'h20);
        step();                                  // ACCESS, wait 1
        chk("r2_paddr_a1",   64'(apb.PADDR), 64'h20);
        step();                                  // ACCESS, wait 2
        chk("r2_paddr_a2",   64'(apb.PADDR), 64'h20);
        chk("r2_no_rsp",     64'(rsp_valid), 64'd0);
        step();                                  // ACCESS, ready now
        chk("r2_paddr_a3",   64'(apb.PADDR), 64'h20);
        chk("r2_pen_a3",     64'(apb.PENABLE), 64'd1);
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'h12345678;
        step();                                  // response, 5th cycle
        chk("r2_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("r2_rsp_rdata",  64'(rsp_rdata), 64'h12345678);
        chk("r2_rsp_err",    64'(rsp_err), 64'd0);
        step();

        // ---- PSLVERR during SETUP only: no error ----
        apb.PSLVERR = 1'b1;
        apb.PRDATA  = 32'h0BADF00D;
        drive_cmd(1'b0, 32'h30, 32'h0);
        step();                                  // SETUP
        cmd_valid = 1'b0;
        step();                                  // ACCESS
        apb.PSLVERR = 1'b0;
        step();
        chk("e0_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("e0_rsp_err",    64'(rsp_err), 64'd0);
        chk("e0_rsp_rdata",  64'(rsp_rdata), 64'h0BADF00D);
        step();

        // ---- slave error in the ready ACCESS cycle ----
        apb.PSLVERR = 1'b1;
        apb.PRDATA  = 32'h0000A5A5;
        drive_cmd(1'b0, 32'h34, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("e1_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("e1_rsp_err",    64'(rsp_err), 64'd1);
        chk("e1_rsp_tmo",    64'(rsp_timeout), 64'd0);
        chk("e1_rsp_rdata",  64'(rsp_rdata), 64'h0000A5A5);
        apb.PSLVERR = 1'b0;
        step();

        // ---- timeout after 16 not-ready ACCESS cycles ----
        apb.PREADY = 1'b0;
        base_cnt = rsp_cnt;
        drive_cmd(1'b1, 32'h40, 32'hCAFEF00D);
        step();                                  // SETUP
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();     // 16 ACCESS cycles
        chk("t_last_psel",   64'(apb.PSEL), 64'd1);
        chk("t_last_pen",    64'(apb.PENABLE), 64'd1);
        chk("t_no_early",    64'(rsp_cnt - base_cnt), 64'd0);
        step();
        chk("t_rsp_valid",   64'(rsp_valid), 64'd1);
        chk("t_rsp_err",     64'(rsp_err), 64'd1);
        chk("t_rsp_tmo",     64'(rsp_timeout), 64'd1);
        chk("t_rsp_rdata",   64'(rsp_rdata), 64'd0);
        chk("t_psel_low",    64'(apb.PSEL), 64'd0);
        step();
        chk("t_flags_hold",  64'(rsp_timeout), 64'd1);

        // ---- normal command after timeout ----
        apb.PREADY = 1'b1;
        drive_cmd(1'b1, 32'h44, 32'h00000055);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t2_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("t2_rsp_err",    64'(rsp_err), 64'd0);
        chk("t2_rsp_tmo",    64'(rsp_timeout), 64'd0);
        step();

        // ---- back-to-back writes with cmd_valid held ----
        base_cnt = rsp_cnt;
        drive_cmd(1'b1, 32'h100, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();                              // SETUP
            chk("b2b_setup_psel", 64'(apb.PSEL), 64'd1);
            chk("b2b_setup_pen",  64'(apb.PENABLE), 64'd0);
            chk("b2b_paddr",      64'(apb.PADDR), 64'(32'h100 + 32'(4 * k)));
            chk("b2b_pwdata",     64'(apb.PWDATA), 64'(k + 1));
            if (k < 2) begin
                cmd_addr  = 32'h100 + 32'(4 * (k + 1));
                cmd_wdata = 32'(k + 2);
            end
            step();                              // ACCESS
            chk("b2b_acc_pen",    64'(apb.PENABLE), 64'd1);
            step();                              // response / idle gap
            chk("b2b_rsp_valid",  64'(rsp_valid), 64'd1);
            chk("b2b_gap_psel",   64'(apb.PSEL), 64'd0);
            chk("b2b_gap_ready",  64'(cmd_ready), 64'd1);
            if (k == 2) cmd_valid = 1'b0;
        end
        step(); step(); step();
        chk("b2b_pulses",    64'(rsp_cnt - base_cnt), 64'd3);
        chk("b2b_idle_psel", 64'(apb.PSEL), 64'd0);

        // ---- reset asserted during ACCESS ----
        apb.PREADY = 1'b0;
        drive_cmd(1'b0, 32'h80, 32'h0);
        step();                                  // SETUP
        cmd_valid = 1'b0;
        step();                                  // ACCESS
        chk("ra_in_access",  64'(apb.PENABLE), 64'd1);
        base_cnt = rsp_cnt;
        #2 PRESETn = 1'b0;
        #1;
        chk("ra_psel_async", 64'(apb.PSEL), 64'd0);
        chk("ra_pen_async",  64'(apb.PENABLE), 64'd0);
        apb.PREADY = 1'b1;
        step(); step();
        PRESETn = 1'b1;
        step();
        chk("ra_ready",      64'(cmd_ready), 64'd1);
        chk("ra_state",      64'(state_dbg), 64'd0);
        step(); step();
        chk("ra_no_rsp",     64'(rsp_cnt - base_cnt), 64'd0);
        chk("ra_psel_idle",  64'(apb.PSEL), 64'd0);

        chk("proto_setup_before_enable", 64'(proto_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
